// File: rtl/bram_burst_master_if.sv
// Signal bundle for bram_burst_master: command port, read/write streams and BRAM bus.
// master = the burst engine, slave = its environment (sequencer, datapath, BRAM).
interface bram_burst_master_if #(
   parameter int LEN_W = 10
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [31:0]      cmd_base;
   logic [LEN_W-1:0] cmd_len;

   logic [31:0]      rd_data;
   logic             rd_valid;
   logic             rd_ready;

   logic [31:0]      wr_data;
   logic             wr_valid;
   logic             wr_ready;

   logic             busy;
   logic             done;
   logic             err;

   logic             R_req;
   logic [31:0]      addr;
   logic [31:0]      R_data;
   logic [3:0]       W_req;
   logic [31:0]      W_data;

   modport master (
      input  cmd_valid, cmd_write, cmd_base, cmd_len,
      input  rd_ready, wr_data, wr_valid, R_data,
      output cmd_ready, rd_data, rd_valid, wr_ready,
      output busy, done, err,
      output R_req, addr, W_req, W_data
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_base, cmd_len,
      output rd_ready, wr_data, wr_valid, R_data,
      input  cmd_ready, rd_data, rd_valid, wr_ready,
      input  busy, done, err,
      input  R_req, addr, W_req, W_data
   );
endinterface

// File: rtl/bram_burst_master.sv
// Burst initiator for a word-addressed BRAM: one command becomes a run of single-word
// reads (returned through a credit-controlled FIFO) or full-word writes (from a stream).
//
// Handshakes: every stream transfers a word on a cycle where valid and ready are both
// high at the rising clock edge; valid never waits on ready, and once the source raises
// valid it keeps valid and data stable until that transfer happens.
module bram_burst_master #(
   parameter int LEN_W      = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   bram_burst_master_if.master bus,
   output logic [2:0]          state_dbg
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_RDRAIN = 3'd2,
      S_WRITE  = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t           state, state_nxt;

   logic [31:0]      cur_addr;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat_cnt;
   logic             beats_left;
   logic             last_beat;
   logic             cmd_fire;
   logic             cmd_bad;
   logic             rd_issue;
   logic             wr_accept;

   logic             r_req_q;
   logic [3:0]       w_req_q;
   logic [31:0]      addr_q;
   logic [31:0]      w_data_q;
   logic             err_q;
   // rd_inflight_q: a read strobe is on the bus; cap_q: its data is on R_data now
   logic             rd_inflight_q;
   logic             cap_q;

   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      fifo_count;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CW-1:0]    credit_used;

   assign beats_left  = (beat_cnt != len_q);
   assign last_beat   = (beat_cnt == len_q - LEN_W'(1));
   assign cmd_fire    = (state == S_IDLE) && bus.cmd_valid;
   assign cmd_bad     = (bus.cmd_len == '0) || (bus.cmd_base[1:0] != 2'b00);
   assign credit_used = CW'(fifo_count) + CW'(rd_inflight_q) + CW'(cap_q);
   assign rd_issue    = (state == S_READ) && beats_left && (credit_used < CW'(FIFO_DEPTH));
   assign wr_accept   = (state == S_WRITE) && beats_left && bus.wr_valid;

   assign fifo_push   = cap_q;
   assign fifo_pop    = (fifo_count != '0) && bus.rd_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_fire && !cmd_bad) state_nxt = bus.cmd_write ? S_WRITE : S_READ;
         end
         S_READ: begin
            if (rd_issue && last_beat) state_nxt = S_RDRAIN;
         end
         S_RDRAIN: begin
            if (!rd_inflight_q && !cap_q && (fifo_count == '0)) state_nxt = S_FINISH;
         end
         S_WRITE: begin
            // beats exhausted means the final write strobe is on the bus this cycle
            if (!beats_left) state_nxt = S_FINISH;
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr      <= '0;
         len_q         <= '0;
         beat_cnt      <= '0;
         r_req_q       <= 1'b0;
         w_req_q       <= 4'b0000;
         addr_q        <= '0;
         w_data_q      <= '0;
         err_q         <= 1'b0;
         rd_inflight_q <= 1'b0;
         cap_q         <= 1'b0;
      end else begin
         err_q         <= cmd_fire && cmd_bad;
         r_req_q       <= rd_issue || wr_accept;
         w_req_q       <= wr_accept ? 4'b1111 : 4'b0000;
         rd_inflight_q <= rd_issue;
         cap_q         <= rd_inflight_q;
         if (rd_issue || wr_accept) begin
            addr_q   <= cur_addr;
            cur_addr <= cur_addr + 32'd4;
            beat_cnt <= beat_cnt + LEN_W'(1);
         end
         if (wr_accept) w_data_q <= bus.wr_data;
         if (cmd_fire && !cmd_bad) begin
            cur_addr <= bus.cmd_base;
            len_q    <= bus.cmd_len;
            beat_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr] <= bus.R_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
         if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_FINISH);
   assign bus.err       = err_q;
   assign bus.wr_ready  = (state == S_WRITE) && beats_left;
   assign bus.rd_valid  = (fifo_count != '0);
   assign bus.rd_data   = fifo_mem[rd_ptr];
   assign bus.R_req     = r_req_q;
   assign bus.W_req     = w_req_q;
   assign bus.addr      = addr_q;
   assign bus.W_data    = w_data_q;
   assign state_dbg     = state;
endmodule

// File: tb/tb_bram_burst_master.sv
// Directed bench for bram_burst_master with a behavioural BRAM and a bus monitor.
// Unwritten BRAM word i reads as 0x9C + i, so words 4..11 hold 0xA0..0xA7.
module tb_bram_burst_master;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] str_addr_q[$];
   logic [31:0] str_wd_q[$];
   logic [3:0]  str_we_q[$];
   int          str_cyc_q[$];

   logic [31:0] mem [512];
   bit          written [512];

   bram_burst_master_if #(.LEN_W(10)) bus ();

   bram_burst_master #(.LEN_W(10), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] default_word(input logic [8:0] i);
      return 32'h9C + {23'd0, i};
   endfunction

   // BRAM: write on R_req with all enables, otherwise read data appears next cycle
   always @(posedge clk) begin
      if (bus.R_req) begin
         if (bus.W_req == 4'hF) begin
            mem[bus.addr[10:2]]     <= bus.W_data;
            written[bus.addr[10:2]] <= 1'b1;
         end else begin
            bus.R_data <= written[bus.addr[10:2]] ? mem[bus.addr[10:2]]
                                                  : default_word(bus.addr[10:2]);
         end
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus.R_req) begin
         str_addr_q.push_back(bus.addr);
         str_wd_q.push_back(bus.W_data);
         str_we_q.push_back(bus.W_req);
         str_cyc_q.push_back(cyc);
      end
      if (bus.rd_valid && bus.rd_ready) got_q.push_back(bus.rd_data);
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.err)  err_cnt  <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [31:0] base, input logic [9:0] len);
      int n = 0;
      while (!bus.cmd_ready && n < 300) begin tick(); n++; end
      check("cmd_ready_wait", 32'(n >= 300), 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_base  = base;
      bus.cmd_len   = len;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d);
      int  n = 0;
      logic acc = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.wr_ready;
         tick();
         n++;
      end
      bus.wr_valid = 1'b0;
      check("wr_beat_wait", 32'(acc), 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 300) begin tick(); n++; end
      check({tag, "_timeout"}, 32'(n >= 300), 0);
   endtask

   task automatic check_reads(input string tag, input int g0);
      int ne = exp_q.size();
      check({tag, "_nread"}, got_q.size() - g0, ne);
      for (int i = 0; i < ne; i++)
         check({tag, "_data"}, (g0 + i < got_q.size()) ? got_q[g0 + i] : 32'hDEAD_DEAD,
               exp_q.pop_front());
   endtask

   task automatic check_strobe(input string tag, input int idx, input logic [31:0] a,
                               input logic [3:0] we);
      check({tag, "_addr"}, (idx < str_addr_q.size()) ? str_addr_q[idx] : 32'hDEAD_DEAD, a);
      check({tag, "_wreq"}, (idx < str_we_q.size()) ? 32'(str_we_q[idx]) : 32'hF0, 32'(we));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, g0, d0, e0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      bus.rd_ready  = 1'b0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;

      // reset state
      repeat (3) tick();
      check("rst_r_req",    32'(bus.R_req), 0);
      check("rst_w_req",    32'(bus.W_req), 0);
      check("rst_addr",     bus.addr, 0);
      check("rst_w_data",   bus.W_data, 0);
      check("rst_done",     32'(bus.done), 0);
      check("rst_err",      32'(bus.err), 0);
      check("rst_busy",     32'(bus.busy), 0);
      check("rst_rd_valid", 32'(bus.rd_valid), 0);
      check("rst_wr_ready", 32'(bus.wr_ready), 0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      check("rst_state",    32'(state_dbg), 0);
      rst = 1'b0;
      tick();

      // read 5 words from 0x10 with the consumer always ready
      bus.rd_ready = 1'b1;
      s0 = str_addr_q.size(); g0 = got_q.size(); d0 = done_cnt;
      send_cmd(1'b0, 32'h10, 10'd5);
      wait_idle("rd5");
      check("rd5_nstrobe", str_addr_q.size() - s0, 5);
      for (int i = 0; i < 5; i++) check_strobe("rd5", s0 + i, 32'h10 + 32'(4 * i), 4'h0);
      for (int i = 0; i < 4; i++)
         check("rd5_consec", (s0 + i + 1 < str_cyc_q.size()) ?
               32'(str_cyc_q[s0 + i + 1] - str_cyc_q[s0 + i]) : 32'hFF, 1);
      for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + 32'(i));
      check_reads("rd5", g0);
      check("rd5_done", done_cnt - d0, 1);
      check("rd5_busy", 32'(bus.busy), 0);

      // same read, consumer stalled for 12 cycles: credit stops issue at 4
      bus.rd_ready = 1'b0;
      s0 = str_addr_q.size(); g0 = got_q.size(); d0 = done_cnt;
      send_cmd(1'b0, 32'h10, 10'd5);
      repeat (12) tick();
      check("stall_issued", str_addr_q.size() - s0, 4);
      check("stall_rd_valid", 32'(bus.rd_valid), 1);
      check("stall_popped", got_q.size() - g0, 0);
      bus.rd_ready = 1'b1;
      wait_idle("stall");
      check("stall_nstrobe", str_addr_q.size() - s0, 5);
      check_strobe("stall_last", s0 + 4, 32'h20, 4'h0);
      for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + 32'(i));
      check_reads("stall", g0);
      check("stall_done", done_cnt - d0, 1);

      // write 3 words at 0 with an idle cycle between beats, then read back
      s0 = str_addr_q.size(); d0 = done_cnt;
      send_cmd(1'b1, 32'h0, 10'd3);
      send_beat(32'h11);
      tick();
      send_beat(32'h22);
      tick();
      send_beat(32'h33);
      wait_idle("wr3");
      check("wr3_nstrobe", str_addr_q.size() - s0, 3);
      for (int i = 0; i < 3; i++) begin
         check_strobe("wr3", s0 + i, 32'(4 * i), 4'hF);
         check("wr3_wdata", (s0 + i < str_wd_q.size()) ? str_wd_q[s0 + i] : 32'hDEAD_DEAD,
               32'h11 * 32'(i + 1));
      end
      check("wr3_gap", (s0 + 1 < str_cyc_q.size()) ?
            32'(str_cyc_q[s0 + 1] - str_cyc_q[s0]) : 32'hFF, 2);
      check("wr3_done", done_cnt - d0, 1);
      g0 = got_q.size();
      send_cmd(1'b0, 32'h0, 10'd3);
      wait_idle("rb3");
      exp_q.push_back(32'h11);
      exp_q.push_back(32'h22);
      exp_q.push_back(32'h33);
      check_reads("rb3", g0);

      // rejected commands: zero length, then misaligned base
      s0 = str_addr_q.size(); d0 = done_cnt; e0 = err_cnt;
      send_cmd(1'b0, 32'h40, 10'd0);
      check("err_len0_pulse", 32'(bus.err), 1);
      check("err_len0_ready", 32'(bus.cmd_ready), 1);
      tick();
      check("err_len0_clear", 32'(bus.err), 0);
      send_cmd(1'b0, 32'h6, 10'd2);
      check("err_align_pulse", 32'(bus.err), 1);
      check("err_align_busy", 32'(bus.busy), 0);
      repeat (3) tick();
      check("err_strobes", str_addr_q.size() - s0, 0);
      check("err_done", done_cnt - d0, 0);
      check("err_count", err_cnt - e0, 2);
      check("err_cmd_ready", 32'(bus.cmd_ready), 1);

      // reset in the middle of an 8-word read after three pops
      bus.rd_ready = 1'b1;
      g0 = got_q.size(); d0 = done_cnt;
      send_cmd(1'b0, 32'h10, 10'd8);
      begin
         int n = 0;
         while ((got_q.size() - g0) < 3 && n < 100) begin tick(); n++; end
         check("mid_pop_wait", 32'(n >= 100), 0);
      end
      bus.rd_ready = 1'b0;
      rst = 1'b1;
      tick();
      check("mid_rst_r_req", 32'(bus.R_req), 0);
      check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
      check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
      rst = 1'b0;
      bus.rd_ready = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) exp_q.push_back(32'hA0 + 32'(i));
      check_reads("mid_pre", g0);
      check("mid_done", done_cnt - d0, 0);
      g0 = got_q.size();
      send_cmd(1'b0, 32'h10, 10'd2);
      wait_idle("mid_fresh");
      exp_q.push_back(32'hA0);
      exp_q.push_back(32'hA1);
      check_reads("mid_fresh", g0);
      check("mid_fresh_done", done_cnt - d0, 1);

      // write then read at 0x7FC, read accepted the cycle after done
      s0 = str_addr_q.size(); g0 = got_q.size();
      send_cmd(1'b1, 32'h7FC, 10'd1);
      send_beat(32'hDEAD_BEEF);
      begin
         int n = 0;
         while (!bus.done && n < 50) begin @(negedge clk); n++; end
         check("b2b_done_wait", 32'(n >= 50), 0);
      end
      tick();
      check("b2b_ready", 32'(bus.cmd_ready), 1);
      send_cmd(1'b0, 32'h7FC, 10'd1);
      check("b2b_busy", 32'(bus.busy), 1);
      wait_idle("b2b");
      check_strobe("b2b_wr", s0, 32'h7FC, 4'hF);
      check_strobe("b2b_rd", s0 + 1, 32'h7FC, 4'h0);
      exp_q.push_back(32'hDEAD_BEEF);
      check_reads("b2b", g0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
